// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Shares one UART transmitter among N_REQ byte-stream clients.
//            Grants are round-robin per packet, and each grant applies the
//            client's baud and parity settings. An idle gap follows each packet.
// Options  : UART_SCHED_TIMEOUT_EN enables the in-packet stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int          N_REQ          = 4,
    parameter int          GAP_CYCLES     = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [12:0] BAUD_RST       = 13'd5208,
    localparam int         GW             = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [13*N_REQ-1:0]  cfg_baud,
    input  logic [N_REQ-1:0]     cfg_parity_en,
    output logic                 uart_tx_valid,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic [12:0]          uart_baud_rate,
    output logic                 uart_parity_en,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int               c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_n_req
        $error("uart_tx_sched: N_REQ must be in 2..8");
    end
    if (GAP_CYCLES < 1) begin : g_chk_gap
        $error("uart_tx_sched: GAP_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("uart_tx_sched: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONFIG  = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_TX = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t               r_state;
    logic [GW-1:0]        r_rr_ptr;
    logic [GW-1:0]        r_grant;
    logic [7:0]           r_tx_data;
    logic                 r_last;
    logic [12:0]          r_baud;
    logic                 r_parity;
    logic [c_gap_w-1:0]   r_gap_cnt;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int               c_to_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
    logic [c_to_w-1:0]    r_to_cnt;
    logic                 r_timeout_err;
`endif

    logic                 w_any_req;
    logic [GW-1:0]        w_pick;
    logic                 w_sel_valid;
    logic [7:0]           w_sel_data;
    logic                 w_sel_last;
    logic [12:0]          w_sel_baud;
    logic                 w_sel_parity;
    logic [N_REQ-1:0]     w_ready;

    // Round-robin search starting just above the last grant, wrapping modulo N_REQ.
    always_comb begin
        int            v_idx;
        logic [GW-1:0] v_sel;
        logic          v_found;
        v_idx     = 0;
        v_sel     = '0;
        v_found   = 1'b0;
        w_pick    = '0;
        w_any_req = |req_valid;
        for (int i = 1; i <= N_REQ; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % N_REQ;
            v_sel = GW'(v_idx);
            if (!v_found && req_valid[v_sel]) begin
                v_found = 1'b1;
                w_pick  = v_sel;
            end
        end
    end

    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_data   = 8'h00;
        w_sel_last   = 1'b0;
        w_sel_baud   = BAUD_RST;
        w_sel_parity = 1'b0;
        w_ready      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid  = req_valid[i];
                w_sel_data   = req_data[i*8 +: 8];
                w_sel_last   = req_last[i];
                w_sel_baud   = cfg_baud[i*13 +: 13];
                w_sel_parity = cfg_parity_en[i];
                w_ready[i]   = (r_state == S_SEND);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= GW'(N_REQ - 1);
            r_grant   <= '0;
            r_tx_data <= 8'h00;
            r_last    <= 1'b0;
            r_baud    <= BAUD_RST;
            r_parity  <= 1'b0;
            r_gap_cnt <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
`ifdef UART_SCHED_TIMEOUT_EN
            r_timeout_err <= 1'b0;
            if (r_state != S_SEND) begin
                r_to_cnt <= '0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant  <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_state  <= S_CONFIG;
                    end
                end
                // Line settings only move here, so a packet never sees a config change.
                S_CONFIG: begin
                    if (!uart_tx_busy) begin
                        r_baud   <= w_sel_baud;
                        r_parity <= w_sel_parity;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_sel_valid) begin
                        r_tx_data <= w_sel_data;
                        r_last    <= w_sel_last;
                        r_state   <= S_WAIT_TX;
                    end
`ifdef UART_SCHED_TIMEOUT_EN
                    else if (r_to_cnt == c_to_last) begin
                        r_timeout_err <= 1'b1;
                        r_gap_cnt     <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_WAIT_TX: begin
                    if (!uart_tx_busy) begin
                        if (r_last) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_state   <= S_SEND;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = w_ready;
    assign uart_tx_valid  = (r_state == S_WAIT_TX);
    assign uart_tx_data   = r_tx_data;
    assign uart_baud_rate = r_baud;
    assign uart_parity_en = r_parity;
    assign grant_id       = r_grant;
    assign active         = (r_state != S_IDLE);
`ifdef UART_SCHED_TIMEOUT_EN
    assign timeout_err    = r_timeout_err;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet-level scheduler that shares one UART transmitter among `N_REQ` byte-stream clients. It arbitrates round-robin at packet boundaries and applies the winning client's baud divisor and parity setting to the transmitter. It then forwards the client's bytes one at a time over a valid/busy handshake and enforces an inter-packet idle gap. It sits between the client sources and the UART TX core.

## Interface
Parameters:
- `N_REQ`, 4: number of clients (2..8); `GW = $clog2(N_REQ)`
- `GAP_CYCLES`, 16: idle clocks after each packet (≥1)
- `TIMEOUT_CYCLES`, 1024: stall limit inside a packet (used only with the macro)
- `BAUD_RST`, 13'd5208: reset value of `uart_baud_rate`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `req_valid`  in  N_REQ  per-client byte valid
- `req_data`  in  8*N_REQ  per-client byte; client i uses `[8i+7:8i]`
- `req_last`  in  N_REQ  byte is last of packet
- `req_ready`  out  N_REQ  byte accepted when `valid&ready`
- `cfg_baud`  in  13*N_REQ  per-client baud divisor
- `cfg_parity_en`  in  N_REQ  per-client parity enable
- `uart_tx_valid`  out  1  byte offered to transmitter
- `uart_tx_data`  out  8  byte to transmit
- `uart_tx_busy`  in  1  transmitter busy; accept = `uart_tx_valid & !uart_tx_busy`
- `uart_baud_rate`  out  13  divisor to transmitter
- `uart_parity_en`  out  1  parity enable to transmitter
- `grant_id`  out  GW  current/last granted client
- `active`  out  1  packet in progress (state ≠ IDLE)
- `timeout_err`  out  1  one-cycle abort pulse

## Operation
- States: IDLE, CONFIG, SEND, WAIT_TX, GAP.
- IDLE: if any `req_valid`, grant the first set bit searching upward from `rr_ptr+1`, wrapping. Register `grant_id` and go to CONFIG. `rr_ptr` is set to the grant.
- CONFIG: wait for `uart_tx_busy==0`. Then load `uart_baud_rate`/`uart_parity_en` from the granted client's config and go to SEND.
  - Config outputs change only in this state, never during a packet.
- SEND: `req_ready[grant_id]=1`; all other `req_ready` bits are 0. On `req_valid[grant_id]`, capture the data byte into `uart_tx_data` and capture the last flag. Go to WAIT_TX.
- WAIT_TX: `uart_tx_valid=1`, holding data stable. On accept, go to GAP if the captured byte was last, else SEND.
- GAP: count `GAP_CYCLES` clocks, then go to IDLE. Requests are ignored.
- Valid on non-granted clients has no effect mid-packet. A client that raises valid first waits for the current packet plus gap.
- A grant is never revoked mid-packet, except by timeout.

## Timing
- Reset values: `req_ready=0`, `uart_tx_valid=0`, `uart_tx_data=0`, `uart_baud_rate=BAUD_RST`, `uart_parity_en=0`, `grant_id=0`, `active=0`, `timeout_err=0`, `rr_ptr=N_REQ-1` (client 0 wins the first tie).
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- With `uart_tx_busy=0`, `req_valid` high in IDLE at edge t leads to:
  - CONFIG after edge t
  - SEND after t+1, with `req_ready` high during cycle t+2
  - byte captured at t+2, `uart_tx_valid` high during cycle t+3
- Per byte, with the transmitter idle: SEND→WAIT_TX→SEND takes 2 cycles. Throughput is limited by `uart_tx_busy`.
- Gap: exactly `GAP_CYCLES` cycles in GAP before IDLE.
- Asynchronous reset mid-packet: immediately go to IDLE and drop `uart_tx_valid`/`req_ready`. A frame already accepted by the transmitter is not aborted.
- Round-robin pointer arithmetic is modulo `N_REQ`.

## Configuration
- `UART_SCHED_TIMEOUT_EN` defined: in SEND, a counter increments each cycle `req_valid[grant_id]==0` and clears on accept or on state entry.
  - When the counter reaches `TIMEOUT_CYCLES`, pulse `timeout_err` for 1 cycle and go to GAP, abandoning the packet.
- Undefined: SEND waits indefinitely, no counter logic is built, and `timeout_err` is tied 0.

## Test plan
- Single client 0, packet {0x55, 0xA3 last}, `cfg_baud[0]`=434, parity on:
  - `uart_baud_rate`=434 and `uart_parity_en`=1 before the first `uart_tx_valid`
  - bytes delivered in order
  - `active` falls exactly 16 cycles after the 0xA3 accept
- Clients 0, 1 and 3 valid simultaneously from reset: grants are 0, 1, 3, then 0 again, one packet each.
- `uart_tx_busy` held high for 50 cycles while in WAIT_TX: `uart_tx_valid` and `uart_tx_data` stay stable; the byte transfers on the first busy-low cycle.
- Client 2 config changes (`cfg_baud[2]` 5208→868) mid-packet: `uart_baud_rate` stays 5208 until the next CONFIG for client 2.
- Async reset asserted in WAIT_TX: `uart_tx_valid`=0 and `req_ready`=0 in the same cycle; after release, client 0 wins first.
- With `UART_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, client stalls after its first byte: `timeout_err` pulses on the 8th stall cycle, then GAP, then another client is granted.
